// File: rtl/bram_arbiter_pkg.sv
// rtl/bram_arbiter_pkg.sv - shared types and read-latency constant for bram_arbiter
// BRAM_ARBITER_RDREG_EN selects the registered read-data path (latency 2).
package bram_arbiter_pkg;

    localparam int MAX_REQ = 8;

    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    localparam int REQ_IDX_W = clog2_min1(MAX_REQ);

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

`ifdef BRAM_ARBITER_RDREG_EN
    localparam int RD_LATENCY = 2;
`else
    localparam int RD_LATENCY = 1;
`endif

endpackage

// File: rtl/bram_arbiter_rr_arbiter.sv
// rtl/bram_arbiter_rr_arbiter.sv - round-robin grant logic owning the priority pointer
module rr_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt,
    output req_idx_t     gnt_idx
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Search upward from the pointer, wrapping at N; first hit wins.
    always_comb begin
        int          idx;
        logic [PW-1:0] idx_w;
        logic        found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = PW'(idx);
            if (!found && req[idx_w]) begin
                found      = 1'b1;
                gnt[idx_w] = 1'b1;
                gnt_idx    = req_idx_t'(idx);
            end
        end
    end

    always_comb begin
        int nxt;
        nxt   = int'(gnt_idx) + 1;
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (nxt >= N) ? '0 : PW'(nxt);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - round-robin sharing of one single-port BRAM among NUM_REQ requesters
// BRAM_ARBITER_RDREG_EN adds an output register on read data (response latency 2).
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int DATA_WIDTH      = 64,
    parameter int BRAM_ADDR_WIDTH = 12
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]      req_we,
    input  logic [NUM_REQ*BRAM_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_wrdata,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [DATA_WIDTH-1:0]                rsp_rddata,
    output logic                                 bram_en,
    output logic [DATA_WIDTH/8-1:0]              bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0]           bram_addr,
    output logic [DATA_WIDTH-1:0]                bram_wrdata,
    input  logic [DATA_WIDTH-1:0]                bram_rddata
);

    localparam int BW = DATA_WIDTH / 8;

    logic [NUM_REQ-1:0] gnt;
    req_idx_t           gnt_idx;
    logic               any_gnt;
    logic               rd_fire;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req_valid),
        .advance (any_gnt),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Reset is asynchronous, so the combinational grant is gated directly by rstn.
    assign req_ready = gnt & {NUM_REQ{rstn}};
    assign any_gnt   = |req_ready;

    always_comb begin
        bram_en     = any_gnt;
        bram_we     = '0;
        bram_addr   = '0;
        bram_wrdata = '0;
        if (any_gnt) begin
            bram_we     = req_we[int'(gnt_idx)*BW +: BW];
            bram_addr   = req_addr[int'(gnt_idx)*BRAM_ADDR_WIDTH +: BRAM_ADDR_WIDTH];
            bram_wrdata = req_wrdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign rd_fire = any_gnt && (bram_we == '0);

    logic     rd_vld_q;
    logic     rd_vld_d;
    req_idx_t rd_idx_q;
    req_idx_t rd_idx_d;

    assign rd_vld_d = rd_fire;
    assign rd_idx_d = rd_fire ? gnt_idx : rd_idx_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            rd_vld_q <= rd_vld_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    logic     rsp_vld_w;
    req_idx_t rsp_idx_w;

`ifdef BRAM_ARBITER_RDREG_EN
    logic                  out_vld_q;
    logic                  out_vld_d;
    req_idx_t              out_idx_q;
    req_idx_t              out_idx_d;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DATA_WIDTH-1:0] out_data_d;

    assign out_vld_d  = rd_vld_q;
    assign out_idx_d  = rd_idx_q;
    assign out_data_d = rd_vld_q ? bram_rddata : out_data_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_vld_q  <= 1'b0;
            out_idx_q  <= '0;
            out_data_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_idx_q  <= out_idx_d;
            out_data_q <= out_data_d;
        end
    end

    assign rsp_vld_w  = out_vld_q;
    assign rsp_idx_w  = out_idx_q;
    assign rsp_rddata = out_data_q;
`else
    assign rsp_vld_w  = rd_vld_q;
    assign rsp_idx_w  = rd_idx_q;
    assign rsp_rddata = bram_rddata;
`endif

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = rsp_vld_w && (rsp_idx_w == req_idx_t'(i));
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - directed self-checking bench for bram_arbiter with a BRAM model
module tb_bram_arbiter;
    import bram_arbiter_pkg::*;

    localparam int NR  = 3;
    localparam int DW  = 64;
    localparam int AW  = 12;
    localparam int BW  = DW / 8;
    localparam int LAT = RD_LATENCY;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*BW-1:0] req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wrdata;
    logic [NR-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_rddata;
    logic            bram_en;
    logic [BW-1:0]   bram_we;
    logic [AW-1:0]   bram_addr;
    logic [DW-1:0]   bram_wrdata;
    logic [DW-1:0]   bram_rddata = '0;

    logic [DW-1:0]   mem [0:4095];
    logic [NR-1:0]   pend_q = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_arbiter #(
        .NUM_REQ(NR),
        .DATA_WIDTH(DW),
        .BRAM_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wrdata(req_wrdata),
        .rsp_valid(rsp_valid),
        .rsp_rddata(rsp_rddata),
        .bram_en(bram_en),
        .bram_we(bram_we),
        .bram_addr(bram_addr),
        .bram_wrdata(bram_wrdata),
        .bram_rddata(bram_rddata)
    );

    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we == '0) begin
                bram_rddata <= mem[bram_addr];
            end else begin
                for (int b = 0; b < BW; b++) begin
                    if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_wrdata[b*8 +: 8];
                end
            end
        end
    end

    // A pending (valid, not ready) request must still be valid next cycle.
    always @(negedge clk) begin
        if (!rstn) begin
            pend_q <= '0;
        end else begin
            if ((pend_q & ~req_valid) != '0) begin
                errors++;
                $display("FAIL req_hold dropped %b pending %b", pend_q & ~req_valid, pend_q);
            end
            pend_q <= req_valid & ~req_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_all();
        req_valid  = '0;
        req_we     = '0;
        req_addr   = '0;
        req_wrdata = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic [BW-1:0] we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_we[i*BW +: BW]   = we;
        req_addr[i*AW +: AW] = a;
        req_wrdata[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        logic [NR-1:0] exp;
        rstn = 1'b0;
        clr_all();
        req_valid = '1;
        tick();
        tick();
        checks++;
        if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b want 000", req_ready); end
        checks++;
        if (bram_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", bram_en); end
        checks++;
        if (rsp_valid !== 3'b000) begin errors++; $display("FAIL reset_rsp got %b want 000", rsp_valid); end
        rstn = 1'b1;
        #1;
        // All requesters valid: grants in order 0,1,2; each drops right after its grant.
        for (int c = 0; c < NR; c++) begin
            exp = '0;
            exp[c] = 1'b1;
            checks++;
            if (req_ready !== exp) begin errors++; $display("FAIL fair_grant%0d got %b want %b", c, req_ready, exp); end
            tick();
            req_valid[c] = 1'b0;
            #1;
        end
        clr_all();
        tick();
        tick();
    endtask

    task automatic test_fairness();
        logic [NR-1:0] exp;
        for (int c = 0; c < 3 * NR; c++) begin
            for (int r = 0; r < NR; r++) begin
                set_req(r, (c <= r + 2 * NR) ? 1'b1 : 1'b0, '0, AW'(r), '0);
            end
            #1;
            exp = '0;
            exp[c % NR] = 1'b1;
            checks++;
            if (req_ready !== exp) begin errors++; $display("FAIL fair_seq%0d got %b want %b", c, req_ready, exp); end
            tick();
        end
        clr_all();
        tick();
        tick();
    endtask

    task automatic test_single_read();
        set_req(1, 1'b1, '0, 12'h010, '0);
        #1;
        checks++;
        if (req_ready !== 3'b010) begin errors++; $display("FAIL rd_ready got %b want 010", req_ready); end
        checks++;
        if (bram_en !== 1'b1) begin errors++; $display("FAIL rd_en got %b want 1", bram_en); end
        checks++;
        if (bram_addr !== 12'h010) begin errors++; $display("FAIL rd_addr got %h want 010", bram_addr); end
        checks++;
        if (bram_we !== 8'h00) begin errors++; $display("FAIL rd_we got %h want 00", bram_we); end
        tick();
        clr_all();
        #1;
        for (int k = 1; k <= LAT + 1; k++) begin
            if (k == LAT) begin
                checks++;
                if (rsp_valid !== 3'b010) begin errors++; $display("FAIL rd_rsp got %b want 010", rsp_valid); end
                checks++;
                if (rsp_rddata !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL rd_data got %h want deadbeefcafef00d", rsp_rddata); end
            end else begin
                checks++;
                if (rsp_valid !== 3'b000) begin errors++; $display("FAIL rd_idle%0d got %b want 000", k, rsp_valid); end
            end
            if (k < LAT + 1) tick();
        end
        tick();
    endtask

    task automatic test_write_read();
        set_req(0, 1'b1, 8'h0F, 12'h020, 64'h11223344_55667788);
        #1;
        checks++;
        if (req_ready !== 3'b001) begin errors++; $display("FAIL wr_ready got %b want 001", req_ready); end
        checks++;
        if (bram_we !== 8'h0F) begin errors++; $display("FAIL wr_we got %h want 0f", bram_we); end
        checks++;
        if (bram_wrdata !== 64'h11223344_55667788) begin errors++; $display("FAIL wr_data got %h want 1122334455667788", bram_wrdata); end
        tick();
        clr_all();
        #1;
        for (int k = 1; k <= LAT + 1; k++) begin
            checks++;
            if (rsp_valid !== 3'b000) begin errors++; $display("FAIL wr_norsp%0d got %b want 000", k, rsp_valid); end
            tick();
        end
        set_req(0, 1'b1, '0, 12'h020, '0);
        #1;
        checks++;
        if (req_ready !== 3'b001) begin errors++; $display("FAIL wrrd_ready got %b want 001", req_ready); end
        tick();
        clr_all();
        #1;
        for (int k = 1; k < LAT; k++) tick();
        checks++;
        if (rsp_valid !== 3'b001) begin errors++; $display("FAIL wrrd_rsp got %b want 001", rsp_valid); end
        checks++;
        if (rsp_rddata !== 64'hFFFFFFFF_55667788) begin errors++; $display("FAIL wrrd_data got %h want ffffffff55667788", rsp_rddata); end
        tick();
        tick();
    endtask

    task automatic test_contention();
        // Pointer is 1 here (last grant went to requester 0).
        set_req(0, 1'b1, '0, 12'h010, '0);
        set_req(1, 1'b1, '0, 12'h020, '0);
        #1;
        checks++;
        if (req_ready !== 3'b010) begin errors++; $display("FAIL cont_first got %b want 010", req_ready); end
        checks++;
        if (bram_addr !== 12'h020) begin errors++; $display("FAIL cont_addr1 got %h want 020", bram_addr); end
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            if (k == 1) begin
                set_req(1, 1'b0, '0, '0, '0);
                #1;
                checks++;
                if (req_ready !== 3'b001) begin errors++; $display("FAIL cont_second got %b want 001", req_ready); end
                checks++;
                if (bram_addr !== 12'h010) begin errors++; $display("FAIL cont_addr2 got %h want 010", bram_addr); end
            end else if (k == 2) begin
                clr_all();
                #1;
            end
            if (k == LAT) begin
                checks++;
                if (rsp_valid !== 3'b010 || rsp_rddata !== 64'hFFFFFFFF_55667788) begin
                    errors++; $display("FAIL cont_rsp1 got %b/%h want 010/ffffffff55667788", rsp_valid, rsp_rddata);
                end
            end else if (k == LAT + 1) begin
                checks++;
                if (rsp_valid !== 3'b001 || rsp_rddata !== 64'hDEADBEEF_CAFEF00D) begin
                    errors++; $display("FAIL cont_rsp2 got %b/%h want 001/deadbeefcafef00d", rsp_valid, rsp_rddata);
                end
            end else begin
                checks++;
                if (rsp_valid !== 3'b000) begin errors++; $display("FAIL cont_idle%0d got %b want 000", k, rsp_valid); end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        set_req(1, 1'b1, '0, 12'h010, '0);
        #1;
        checks++;
        if (req_ready !== 3'b010) begin errors++; $display("FAIL mid_ready got %b want 010", req_ready); end
        tick();
        clr_all();
        rstn = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 3'b000) begin errors++; $display("FAIL mid_rsp_rst got %b want 000", rsp_valid); end
        tick();
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (rsp_valid !== 3'b000) begin errors++; $display("FAIL mid_rsp_after%0d got %b want 000", k, rsp_valid); end
            tick();
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = '0;
        mem[12'h010] = 64'hDEADBEEF_CAFEF00D;
        mem[12'h020] = 64'hFFFFFFFF_FFFFFFFF;
        clr_all();
        test_reset();
        test_fairness();
        test_single_read();
        test_write_read();
        test_contention();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
